// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generators and detectors.
// The state encoding is fixed so that detectors and benches can decode it.
package seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_SEND = 2'b01;
  localparam logic [1:0] ST_GAP  = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  localparam logic [3:0] PAT_1100 = 4'b1100;

endpackage

// File: rtl/seq_dcnt.sv
// Loadable down-counter that saturates at zero, so callers never see a wrap.
// Load takes priority over enable.
module seq_dcnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        r_cnt <= '0;
    else if (i_load)                 r_cnt <= i_val;
    else if (i_en && r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/seq_gen_1100.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, rpt times,
// with gap idle cycles between repeats. Moore FSM with registered outputs.
module seq_gen_1100
  import seq_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_DEF = PAT_W'(PAT_1100),
  parameter int               RPT_W   = 8,
  parameter int               GAP_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             use_def,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [RPT_W-1:0] rpt,
  input  logic [GAP_W-1:0] gap,
  input  logic             hold,
  input  logic             abort,
  output logic             o,
  output logic             o_vld,
  output logic             busy,
  output logic             done
);

  localparam int             BW      = $clog2(PAT_W);
  localparam logic [BW-1:0]  BIT_MSB = BW'(PAT_W - 1);

  logic [1:0]       r_st;
  logic [PAT_W-1:0] r_pat;
  logic [GAP_W-1:0] r_gap;
  logic             r_o;
  logic             r_vld;
  logic             r_busy;
  logic             r_done;

  logic [1:0]       w_st_nxt;
  logic             w_o_nxt;
  logic             w_vld_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_lat;
  logic [PAT_W-1:0] w_pat_sel;

  logic             w_bit_ld, w_bit_en, w_bit_zero;
  logic             w_rep_ld, w_rep_en, w_rep_zero;
  logic             w_gap_ld, w_gap_en, w_gap_zero;
  logic [BW-1:0]    w_bit_cnt;
  logic [BW-1:0]    w_bit_dec;
  logic [RPT_W-1:0] w_rep_cnt;
  logic [GAP_W-1:0] w_gap_cnt;
  logic             w_rep_last;
  logic             w_gap_last;

  assign w_pat_sel = use_def ? PAT_DEF : pat_in;
  assign w_bit_dec = w_bit_cnt - 1'b1;

  // Zero checks guard against a counter that somehow arrives empty:
  // treat it as the final step rather than decrementing past zero.
  assign w_rep_last = w_rep_zero || (w_rep_cnt == RPT_W'(1));
  assign w_gap_last = w_gap_zero || (w_gap_cnt == GAP_W'(1));

  seq_dcnt #(.W(BW)) u_bit_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_bit_ld),
    .i_val  (BIT_MSB),
    .i_en   (w_bit_en),
    .o_cnt  (w_bit_cnt),
    .o_zero (w_bit_zero)
  );

  seq_dcnt #(.W(RPT_W)) u_rep_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_rep_ld),
    .i_val  (rpt),
    .i_en   (w_rep_en),
    .o_cnt  (w_rep_cnt),
    .o_zero (w_rep_zero)
  );

  seq_dcnt #(.W(GAP_W)) u_gap_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_gap_ld),
    .i_val  (r_gap),
    .i_en   (w_gap_en),
    .o_cnt  (w_gap_cnt),
    .o_zero (w_gap_zero)
  );

  // Outputs are computed for the next state so they appear registered
  // in the same cycle the state register takes its new value.
  always_comb begin
    w_st_nxt   = r_st;
    w_o_nxt    = 1'b0;
    w_vld_nxt  = 1'b0;
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    w_lat      = 1'b0;
    w_bit_ld   = 1'b0;
    w_bit_en   = 1'b0;
    w_rep_ld   = 1'b0;
    w_rep_en   = 1'b0;
    w_gap_ld   = 1'b0;
    w_gap_en   = 1'b0;

    if (abort) begin
      w_st_nxt = ST_IDLE;
    end else begin
      case (r_st)
        ST_IDLE: begin
          if (start) begin
            w_lat    = 1'b1;
            w_bit_ld = 1'b1;
            w_rep_ld = 1'b1;
            if (rpt == '0) begin
              w_st_nxt   = ST_DONE;
              w_done_nxt = 1'b1;
            end else begin
              w_st_nxt   = ST_SEND;
              w_o_nxt    = w_pat_sel[PAT_W-1];
              w_vld_nxt  = 1'b1;
              w_busy_nxt = 1'b1;
            end
          end
        end

        ST_SEND: begin
          if (hold) begin
            w_o_nxt    = r_o;
            w_busy_nxt = 1'b1;
          end else if (!w_bit_zero) begin
            w_bit_en   = 1'b1;
            w_o_nxt    = r_pat[w_bit_dec];
            w_vld_nxt  = 1'b1;
            w_busy_nxt = 1'b1;
          end else begin
            w_rep_en = 1'b1;
            if (w_rep_last) begin
              w_st_nxt   = ST_DONE;
              w_done_nxt = 1'b1;
            end else if (r_gap == '0) begin
              w_bit_ld   = 1'b1;
              w_o_nxt    = r_pat[PAT_W-1];
              w_vld_nxt  = 1'b1;
              w_busy_nxt = 1'b1;
            end else begin
              w_st_nxt   = ST_GAP;
              w_gap_ld   = 1'b1;
              w_busy_nxt = 1'b1;
            end
          end
        end

        ST_GAP: begin
          if (hold) begin
            w_o_nxt    = r_o;
            w_busy_nxt = 1'b1;
          end else if (w_gap_last) begin
            w_st_nxt   = ST_SEND;
            w_bit_ld   = 1'b1;
            w_o_nxt    = r_pat[PAT_W-1];
            w_vld_nxt  = 1'b1;
            w_busy_nxt = 1'b1;
          end else begin
            w_gap_en   = 1'b1;
            w_busy_nxt = 1'b1;
          end
        end

        default: begin
          w_st_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_st   <= ST_IDLE;
      r_o    <= 1'b0;
      r_vld  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_st   <= w_st_nxt;
      r_o    <= w_o_nxt;
      r_vld  <= w_vld_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pat <= '0;
      r_gap <= '0;
    end else if (w_lat) begin
      r_pat <= w_pat_sel;
      r_gap <= gap;
    end
  end

  assign o     = r_o;
  assign o_vld = r_vld;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_seq_gen_1100.sv
// Bench for seq_gen_1100: directed scenarios plus randomized runs against a
// stream-level reference model (expected per-cycle output list, hold freezes it).
module tb_seq_gen_1100;

  typedef struct packed {
    logic o;
    logic v;
    logic b;
    logic d;
  } ob_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, use_def, hold, abort;
  logic [3:0] pat_in;
  logic [7:0] rpt;
  logic [3:0] gap;
  logic       o, o_vld, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  seq_gen_1100 dut (
    .clk     (clk),
    .rst     (rst_n),
    .start   (start),
    .use_def (use_def),
    .pat_in  (pat_in),
    .rpt     (rpt),
    .gap     (gap),
    .hold    (hold),
    .abort   (abort),
    .o       (o),
    .o_vld   (o_vld),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Drives one run starting right now (caller sits just after a negedge) and
  // checks every cycle against the model until the first idle cycle after done.
  task automatic run_seq(input string nm, input logic ud, input logic [3:0] p,
                         input logic [7:0] rp, input logic [3:0] gp,
                         input logic [63:0] hm, input bit scr,
                         output int vld_n, output int busy_n, output int done_n,
                         output int done_cyc, output int det_n, output string bits);
    ob_t        exp[$];
    ob_t        cur;
    logic [3:0] ep;
    logic [3:0] sh;
    logic       hb;
    int         idx;
    int         nb;
    bit         fin;
    ep = ud ? 4'b1100 : p;
    for (int r = 0; r < int'(rp); r++) begin
      for (int b = 3; b >= 0; b--) exp.push_back('{ep[b], 1'b1, 1'b1, 1'b0});
      if (r != int'(rp) - 1)
        for (int g = 0; g < int'(gp); g++) exp.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
    end
    exp.push_back('{1'b0, 1'b0, 1'b0, 1'b1});

    vld_n = 0; busy_n = 0; done_n = 0; done_cyc = -1; det_n = 0; bits = "";
    sh = '0; nb = 0; idx = -1; cur = '0; fin = 0;
    start = 1'b1; use_def = ud; pat_in = p; rpt = rp; gap = gp; hold = hm[0]; abort = 1'b0;
    for (int c = 0; c < 200; c++) begin
      hb = hold;
      @(negedge clk);
      if (idx < 0) begin
        idx = 0;
        cur = exp[0];
      end else if (hb && cur.b) begin
        cur.v = 1'b0;
      end else begin
        idx++;
        cur = (idx < exp.size()) ? exp[idx] : ob_t'('0);
      end
      n_cmp += 4;
      if (o !== cur.o) begin
        n_err++; $display("FAIL %s cyc%0d o: got %b want %b", nm, c + 1, o, cur.o);
      end
      if (o_vld !== cur.v) begin
        n_err++; $display("FAIL %s cyc%0d o_vld: got %b want %b", nm, c + 1, o_vld, cur.v);
      end
      if (busy !== cur.b) begin
        n_err++; $display("FAIL %s cyc%0d busy: got %b want %b", nm, c + 1, busy, cur.b);
      end
      if (done !== cur.d) begin
        n_err++; $display("FAIL %s cyc%0d done: got %b want %b", nm, c + 1, done, cur.d);
      end
      if (o_vld === 1'b1) begin
        vld_n++;
        bits = {bits, (o === 1'b1) ? "1" : "0"};
        sh = {sh[2:0], o};
        nb++;
        if (nb >= 4 && sh == 4'b1100) det_n++;
      end
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
        done_n++;
        if (done_cyc < 0) done_cyc = c + 1;
      end
      if (idx >= exp.size()) begin
        fin = 1;
        break;
      end
      start = (scr && (cur.b || cur.d)) ? 1'($urandom % 2) : 1'b0;
      hold  = (c < 63) ? hm[c + 1] : 1'b0;
      if (scr) begin
        use_def = 1'($urandom % 2);
        pat_in  = 4'($urandom);
        rpt     = 8'($urandom);
        gap     = 4'($urandom);
      end
    end
    start = 1'b0; hold = 1'b0;
    n_cmp++;
    if (!fin) begin
      n_err++; $display("FAIL %s run did not finish within 200 cycles", nm);
    end
  endtask

  task automatic chk_idle(input string nm, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({o, o_vld, busy, done} !== 4'b0000) begin
        n_err++;
        $display("FAIL %s idle cyc%0d {o,vld,busy,done}: got %b want 0000", nm, c, {o, o_vld, busy, done});
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; use_def = 1'b1; pat_in = 4'hF; rpt = 8'd3;
    gap = 4'd0; hold = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({o, o_vld, busy, done} !== 4'b0000) begin
      n_err++; $display("FAIL reset_hold outs: got %b want 0000", {o, o_vld, busy, done});
    end
    start = 1'b0;
    rst_n = 1'b1;
    chk_idle("reset_release", 2);
  endtask

  task automatic test_default();
    int v, b, d, dc, det; string s;
    run_seq("default", 1'b1, 4'h0, 8'd1, 4'd0, 64'd0, 0, v, b, d, dc, det, s);
    n_cmp += 3;
    if (s != "1100") begin n_err++; $display("FAIL default bits: got %s want 1100", s); end
    if (b != 4)      begin n_err++; $display("FAIL default busy_cycles: got %0d want 4", b); end
    if (dc != 5)     begin n_err++; $display("FAIL default done_cycle: got %0d want 5", dc); end
  endtask

  task automatic test_back_to_back();
    int v, b, d, dc, det; string s;
    run_seq("b2b", 1'b1, 4'h0, 8'd2, 4'd0, 64'd0, 0, v, b, d, dc, det, s);
    n_cmp += 4;
    if (s != "11001100") begin n_err++; $display("FAIL b2b bits: got %s want 11001100", s); end
    if (det != 2)        begin n_err++; $display("FAIL b2b detections: got %0d want 2", det); end
    if (d != 1)          begin n_err++; $display("FAIL b2b done_pulses: got %0d want 1", d); end
    if (dc != 9)         begin n_err++; $display("FAIL b2b done_cycle: got %0d want 9", dc); end
    // restart in the idle cycle right after done
    run_seq("b2b_restart", 1'b0, 4'b0110, 8'd1, 4'd2, 64'd0, 0, v, b, d, dc, det, s);
    n_cmp++;
    if (s != "0110") begin n_err++; $display("FAIL b2b_restart bits: got %s want 0110", s); end
  endtask

  task automatic test_gap();
    int v, b, d, dc, det; string s;
    run_seq("gap", 1'b0, 4'b1011, 8'd2, 4'd3, 64'd0, 0, v, b, d, dc, det, s);
    n_cmp += 3;
    if (s != "10111011") begin n_err++; $display("FAIL gap bits: got %s want 10111011", s); end
    if (b != 11)         begin n_err++; $display("FAIL gap busy_cycles: got %0d want 11", b); end
    if (dc != 12)        begin n_err++; $display("FAIL gap done_cycle: got %0d want 12", dc); end
  endtask

  task automatic test_rpt_zero();
    int v, b, d, dc, det; string s;
    run_seq("rpt0", 1'b1, 4'h0, 8'd0, 4'd2, 64'd0, 0, v, b, d, dc, det, s);
    n_cmp += 3;
    if (v != 0)  begin n_err++; $display("FAIL rpt0 valid_bits: got %0d want 0", v); end
    if (b != 0)  begin n_err++; $display("FAIL rpt0 busy_cycles: got %0d want 0", b); end
    if (dc != 1) begin n_err++; $display("FAIL rpt0 done_cycle: got %0d want 1", dc); end
  endtask

  task automatic test_hold();
    int v, b, d, dc, det; string s;
    run_seq("hold", 1'b1, 4'h0, 8'd1, 4'd0, 64'b1100, 0, v, b, d, dc, det, s);
    n_cmp += 3;
    if (s != "1100") begin n_err++; $display("FAIL hold bits: got %s want 1100", s); end
    if (b != 6)      begin n_err++; $display("FAIL hold busy_cycles: got %0d want 6", b); end
    if (dc != 7)     begin n_err++; $display("FAIL hold done_cycle: got %0d want 7", dc); end
  endtask

  task automatic test_abort();
    int v, b, d, dc, det; string s;
    logic [2:0] want[3];
    want[0] = 3'b111; want[1] = 3'b111; want[2] = 3'b011;
    start = 1'b1; use_def = 1'b1; rpt = 8'd1; gap = 4'd0; hold = 1'b0; abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if ({o, o_vld, busy} !== want[c]) begin
        n_err++; $display("FAIL abort_pre cyc%0d {o,vld,busy}: got %b want %b", c + 1, {o, o_vld, busy}, want[c]);
      end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if ({o, o_vld, busy, done} !== 4'b0000) begin
      n_err++; $display("FAIL abort_after outs: got %b want 0000", {o, o_vld, busy, done});
    end
    chk_idle("abort_quiet", 4);
    run_seq("abort_rerun", 1'b1, 4'h0, 8'd1, 4'd0, 64'd0, 0, v, b, d, dc, det, s);
  endtask

  task automatic test_rst_mid_gap();
    int v, b, d, dc, det; string s;
    start = 1'b1; use_def = 1'b0; pat_in = 4'b1011; rpt = 8'd2; gap = 4'd3;
    hold = 1'b0; abort = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_cmp++;
    if ({o_vld, busy} !== 2'b01) begin
      n_err++; $display("FAIL rst_gap in_gap {vld,busy}: got %b want 01", {o_vld, busy});
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o, o_vld, busy, done} !== 4'b0000) begin
      n_err++; $display("FAIL rst_gap async outs: got %b want 0000", {o, o_vld, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle("rst_gap_quiet", 4);
    run_seq("rst_gap_rerun", 1'b0, 4'b1011, 8'd2, 4'd3, 64'd0, 0, v, b, d, dc, det, s);
  endtask

  task automatic test_random();
    int v, b, d, dc, det; string s;
    for (int k = 0; k < 12; k++) begin
      run_seq($sformatf("rand%0d", k), 1'($urandom % 2), 4'($urandom),
              8'($urandom_range(0, 4)), 4'($urandom_range(0, 3)),
              {$urandom, $urandom} & {$urandom, $urandom}, 1,
              v, b, d, dc, det, s);
      n_cmp++;
      if (d != 1) begin n_err++; $display("FAIL rand%0d done_pulses: got %0d want 1", k, d); end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_back_to_back();
    test_gap();
    test_rpt_zero();
    test_hold();
    test_abort();
    test_rst_mid_gap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
